// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, reset vector, bubble encoding
// and the per-edge action the fetch pipeline takes.
package instruction_fetch_unit_pkg;

  localparam int DataWidthDefault = 16;
  localparam int AddrBitsDefault = 16;
  localparam int ResetVectorDefault = 0;

  // Later stages treat an InstrValid=0 slot as this instruction.
  localparam logic [15:0] NopEncoding = 16'h0000;

  typedef enum logic [1:0] {
    ActAdvance,
    ActStall,
    ActBranch
  } fetchAction_t;

  // A branch redirect always beats a decode stall.
  function automatic fetchAction_t decodeAction(input logic branchTaken, input logic stall);
    if (branchTaken) return ActBranch;
    if (stall) return ActStall;
    return ActAdvance;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry holding register for the instruction whose memory data arrives
// while decode is stalled; selData presents it in place of live memory data.
module fetch_skid_buffer #(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [DataWidth-1:0] readData,
  input  logic                 captureEn,
  input  logic                 flush,
  output logic                 skidValid,
  output logic [DataWidth-1:0] selData
);

  logic [DataWidth-1:0] skidDataReg;
  logic                 skidValidReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      skidDataReg  <= '0;
      skidValidReg <= 1'b0;
    end else if (flush) begin
      skidValidReg <= 1'b0;
    end else if (captureEn) begin
      skidDataReg  <= readData;
      skidValidReg <= 1'b1;
    end
  end

  assign skidValid = skidValidReg;
  assign selData   = skidValidReg ? skidDataReg : readData;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, pairs one-cycle-latency memory data with the PC
// that requested it, and drives the IF/ID register with stall and redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DataWidth = DataWidthDefault,
  parameter int AddrBits = AddrBitsDefault,
  parameter logic [AddrBits-1:0] ResetVector = AddrBits'(ResetVectorDefault)
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  output logic [AddrBits-1:0]  ReadAddr,
  input  logic [DataWidth-1:0] ReadData,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [AddrBits-1:0]  BranchTarget,
  output logic [DataWidth-1:0] Instr,
  output logic [AddrBits-1:0]  InstrPC,
  output logic [AddrBits-1:0]  InstrPCPlus1,
  output logic                 InstrValid
);

  fetchAction_t         action;
  logic [AddrBits-1:0]  pcReg;
  logic [AddrBits-1:0]  f2PcReg;
  logic                 f2ValidReg;
  logic [DataWidth-1:0] instrReg;
  logic [AddrBits-1:0]  instrPcReg;
  logic [AddrBits-1:0]  instrPcPlus1Reg;
  logic                 instrValidReg;
  logic                 skidValid;
  logic [DataWidth-1:0] selData;
  logic                 skidCapture;
  logic                 skidFlush;

  assign action = decodeAction(BranchTaken, Stall);

  // Only the first stall edge sees data for f2PcReg; later ones see a re-read of pcReg.
  assign skidCapture = (action == ActStall) && !skidValid && f2ValidReg;
  assign skidFlush   = (action != ActStall);

  fetch_skid_buffer #(
    .DataWidth(DataWidth)
  ) skid (
    .clk      (CLK),
    .rstN     (RST_n),
    .readData (ReadData),
    .captureEn(skidCapture),
    .flush    (skidFlush),
    .skidValid(skidValid),
    .selData  (selData)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pcReg           <= ResetVector;
      f2PcReg         <= '0;
      f2ValidReg      <= 1'b0;
      instrReg        <= DataWidth'(NopEncoding);
      instrPcReg      <= '0;
      instrPcPlus1Reg <= '0;
      instrValidReg   <= 1'b0;
    end else begin
      case (action)
        ActBranch: begin
          pcReg         <= BranchTarget;
          f2ValidReg    <= 1'b0;
          instrValidReg <= 1'b0;
        end
        ActAdvance: begin
          instrReg        <= selData;
          instrPcReg      <= f2PcReg;
          instrPcPlus1Reg <= f2PcReg + AddrBits'(1);
          instrValidReg   <= f2ValidReg;
          f2PcReg         <= pcReg;
          f2ValidReg      <= 1'b1;
          pcReg           <= pcReg + AddrBits'(1);
        end
        default: ;
      endcase
    end
  end

  assign ReadAddr     = pcReg;
  assign Instr        = instrReg;
  assign InstrPC      = instrPcReg;
  assign InstrPCPlus1 = instrPcPlus1Reg;
  assign InstrValid   = instrValidReg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scenarios plus randomized stall/branch traffic, checked against a
// delivery-stream model of the fetch stage.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [15:0] readAddr, readData;
  logic        stall = 1'b0, branchTaken = 1'b0;
  logic [15:0] branchTarget = '0;
  logic [15:0] instr, instrPc, instrPcPlus1;
  logic        instrValid;

  logic [15:0] readAddr2, readData2;
  logic        tieLow = 1'b0;
  logic [15:0] tieZero = '0;
  logic [15:0] instr2, instrPc2, instrPcPlus12;
  logic        instrValid2;

  logic [15:0] mem [0:65535];

  int vectors = 0;
  int miscompares = 0;

  // Delivery model: next address to hand to decode and bubbles still owed.
  logic [15:0] mdlNext;
  int          mdlBub;
  logic        expValid;
  logic [15:0] expInstr, expPc, expPlus1, expAddr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    readData  <= mem[readAddr];
    readData2 <= mem[readAddr2];
  end

  instruction_fetch_unit #(.DataWidth(16), .AddrBits(16), .ResetVector(16'h0000)) dut (
    .CLK(clk), .RST_n(rstN), .ReadAddr(readAddr), .ReadData(readData),
    .Stall(stall), .BranchTaken(branchTaken), .BranchTarget(branchTarget),
    .Instr(instr), .InstrPC(instrPc), .InstrPCPlus1(instrPcPlus1), .InstrValid(instrValid)
  );

  instruction_fetch_unit #(.DataWidth(16), .AddrBits(16), .ResetVector(16'hFFFF)) dutWrap (
    .CLK(clk), .RST_n(rstN), .ReadAddr(readAddr2), .ReadData(readData2),
    .Stall(tieLow), .BranchTaken(tieLow), .BranchTarget(tieZero),
    .Instr(instr2), .InstrPC(instrPc2), .InstrPCPlus1(instrPcPlus12), .InstrValid(instrValid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input string tag, input logic [15:0] i, input logic [15:0] p);
    check({tag, " valid"}, instrValid, 1);
    check({tag, " instr"}, instr, i);
    check({tag, " pc"}, instrPc, p);
    check({tag, " pc+1"}, instrPcPlus1, p + 16'd1);
    $display("  %s: instr=%h pc=%h pc+1=%h valid=%b", tag, instr, instrPc, instrPcPlus1, instrValid);
  endtask

  // Apply one edge's inputs, advance the model, compare.
  task automatic step(input logic st, input logic br, input logic [15:0] tgt);
    stall = st;
    branchTaken = br;
    branchTarget = tgt;
    @(posedge clk);
    #1;
    if (br) begin
      expValid = 1'b0;
      mdlNext = tgt;
      mdlBub = 1;
    end else if (!st) begin
      if (mdlBub > 0) begin
        expValid = 1'b0;
        mdlBub--;
      end else begin
        expValid = 1'b1;
        expPc = mdlNext;
        expInstr = mem[mdlNext];
        mdlNext = mdlNext + 16'd1;
      end
    end
    expPlus1 = expPc + 16'd1;
    expAddr = (mdlBub > 0) ? mdlNext : mdlNext + 16'd1;
    check("model valid", instrValid, expValid);
    if (expValid) begin
      check("model instr", instr, expInstr);
      check("model pc", instrPc, expPc);
      check("model pc+1", instrPcPlus1, expPlus1);
    end
    check("model readaddr", readAddr, expAddr);
    stall = 1'b0;
    branchTaken = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic doReset();
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("async valid", instrValid, 0);
    check("async readaddr", readAddr, 16'h0000);
    check("async readaddr wrap", readAddr2, 16'hFFFF);
    @(posedge clk);
    #1;
    check("rst instr", instr, 0);
    check("rst pc", instrPc, 0);
    check("rst pc+1", instrPcPlus1, 0);
    check("rst valid", instrValid, 0);
    check("rst valid wrap", instrValid2, 0);
    $display("  reset: valid=%b readaddr=%h instr=%h", instrValid, readAddr, instr);
    @(negedge clk);
    #2;
    rstN = 1'b1;
    mdlNext = 16'h0000;
    mdlBub = 1;
    expValid = 1'b0;
    expPc = '0;
    expInstr = '0;
  endtask

  task automatic runToSecond();
    step(0, 0, 0);
    check("latency edge1", instrValid, 0);
    step(0, 0, 0);
    expectOut("edge2", 16'h1111, 16'h0000);
    step(0, 0, 0);
    expectOut("edge3", 16'h2222, 16'h0001);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[8] = 16'h8888; mem[9] = 16'h9999; mem[16'hFFFF] = 16'hFACE;

    // Scenario 1 and wrapping-reset-vector instance
    doReset();
    step(0, 0, 0);
    check("s1 edge1 valid", instrValid, 0);
    check("s5 edge1 valid", instrValid2, 0);
    step(0, 0, 0);
    expectOut("s1 a", 16'h1111, 16'h0000);
    check("s5 instr", instr2, 16'hFACE);
    check("s5 pc", instrPc2, 16'hFFFF);
    check("s5 pc+1", instrPcPlus12, 16'h0000);
    check("s5 valid", instrValid2, 1);
    step(0, 0, 0);
    expectOut("s1 b", 16'h2222, 16'h0001);
    check("s5 instr next", instr2, 16'h1111);
    check("s5 pc next", instrPc2, 16'h0000);
    check("s5 pc+1 next", instrPcPlus12, 16'h0001);
    step(0, 0, 0);
    expectOut("s1 c", 16'h3333, 16'h0002);
    step(0, 0, 0);
    expectOut("s1 d", 16'h4444, 16'h0003);

    // Scenario 2: three-cycle stall on 2222
    doReset();
    runToSecond();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      expectOut("s2 hold", 16'h2222, 16'h0001);
    end
    step(0, 0, 0);
    expectOut("s2 after", 16'h3333, 16'h0002);
    step(0, 0, 0);
    expectOut("s2 after2", 16'h4444, 16'h0003);

    // Scenario 3: branch to 8
    doReset();
    runToSecond();
    step(0, 1, 16'h0008);
    check("s3 bubble1", instrValid, 0);
    step(0, 0, 0);
    check("s3 bubble2", instrValid, 0);
    step(0, 0, 0);
    expectOut("s3 target", 16'h8888, 16'h0008);
    step(0, 0, 0);
    expectOut("s3 target+1", 16'h9999, 16'h0009);

    // Scenario 4: branch together with stall
    doReset();
    runToSecond();
    step(1, 1, 16'h0008);
    check("s4 flush", instrValid, 0);
    step(0, 0, 0);
    check("s4 bubble", instrValid, 0);
    step(0, 0, 0);
    expectOut("s4 target", 16'h8888, 16'h0008);

    // Scenario 6: reset pulse mid-stream then restart
    for (int k = 0; k < 2; k++) step(0, 0, 0);
    doReset();
    runToSecond();
    step(0, 0, 0);
    expectOut("s6 c", 16'h3333, 16'h0002);

    // Randomized stall/branch traffic, including redirects near the wrap point
    for (int n = 0; n < 400; n++) begin
      logic st, br;
      logic [15:0] tgt;
      st = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      step(st, br, tgt);
      $display("  rand %0d: st=%b br=%b tgt=%h -> instr=%h pc=%h valid=%b", n, st, br, tgt, instr, instrPc, instrValid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the Instruction_Memory read port.
- Owns the program counter and drives ReadAddr every cycle.
- Consumes the one-cycle-latency ReadData, aligns each instruction with the PC that fetched it, and presents the pair to the IF/ID boundary.
- Handles decode-side stall via a one-entry skid buffer, and handles branch redirect with flush.

Parameters:
- DataWidth, 16, instruction width; must match Instruction_Memory.
- AddrBits, 16, address and PC width; must match Instruction_Memory.
- ResetVector, 0, first fetch address after reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- ReadAddr  output  AddrBits  address to Instruction_Memory; equals the PC register.
- ReadData  input  DataWidth  memory data for the ReadAddr sampled at the previous rising edge.
- Stall  input  1  decode cannot accept; hold the IF/ID outputs.
- BranchTaken  input  1  redirect the fetch stream.
- BranchTarget  input  AddrBits  redirect address; valid when BranchTaken=1.
- Instr  output  DataWidth  fetched instruction (IF/ID register).
- InstrPC  output  AddrBits  address of Instr.
- InstrPCPlus1  output  AddrBits  InstrPC+1, registered.
- InstrValid  output  1  Instr/InstrPC are a real fetch, not a bubble.

Behaviour:
- Internal registers:
  - PC (drives ReadAddr).
  - F2_PC and F2_Valid: the address issued last edge, whose data is on ReadData this cycle.
  - SkidData and SkidValid.
  - Output registers.
- Reset (async, RST_n=0):
  - PC=ResetVector; F2_PC=0, F2_Valid=0.
  - SkidValid=0, SkidData=0.
  - Instr=0, InstrPC=0, InstrPCPlus1=0, InstrValid=0.
  - Reset asserted mid-operation discards all in-flight fetches immediately.
- Memory timing: ReadData in cycle n+1 = mem[ReadAddr during cycle n].
- Latency: first valid instruction appears 2 edges after reset release. Edge 1 moves ResetVector into F2. Edge 2 loads Instr=mem[ResetVector].
- Normal edge (BranchTaken=0, Stall=0):
  - Instr <= SkidValid ? SkidData : ReadData.
  - InstrPC <= F2_PC; InstrPCPlus1 <= F2_PC+1; InstrValid <= F2_Valid.
  - F2_PC <= PC; F2_Valid <= 1.
  - PC <= PC+1; SkidValid <= 0.
  - Sustained throughput: one instruction per cycle.
- Stall edge (BranchTaken=0, Stall=1):
  - Output registers, PC, F2_PC and F2_Valid hold.
  - If SkidValid=0 and F2_Valid=1: SkidData <= ReadData, SkidValid <= 1. This captures data for F2_PC before memory output changes.
  - Later stall edges leave the skid untouched, since ReadData is stale during the stall.
  - Stall of any length loses no instruction and duplicates none.
- Branch edge (BranchTaken=1; overrides Stall):
  - PC <= BranchTarget.
  - F2_Valid <= 0, SkidValid <= 0, InstrValid <= 0.
  - Instr and InstrPC are don't-care and hold.
  - Target instruction appears with InstrValid=1 exactly 2 edges later, provided there is no stall. Branch penalty is 2 bubbles.
- Simultaneous BranchTaken and Stall: branch wins and the flush proceeds. The stalled IF/ID contents are discarded.
- Arithmetic:
  - PC+1 and InstrPCPlus1 are modulo 2^AddrBits.
  - PC=all-ones wraps to 0 with no flag.
- Stall while InstrValid=0: legal, and the bubble holds.
- ReadAddr changes only on CLK edges or reset; it has no combinational path from any input.

Decomposition:
- Shared package holds:
  - DataWidth and AddrBits defaults, shared with Instruction_Memory.
  - ResetVector.
  - The NOP encoding, used by later stages to interpret InstrValid=0.
- One sub-module, fetch_skid_buffer. It is a one-entry DataWidth register with capture, valid, clear and bypass mux. Inputs: ReadData, capture enable, flush.

Test Plan:
Memory preload for all scenarios: mem[0]=16'h1111, mem[1]=16'h2222, mem[2]=16'h3333, mem[3]=16'h4444, mem[8]=16'h8888, mem[9]=16'h9999.
1. Reset release, no stall: InstrValid rises at edge 2. Then Instr/InstrPC go 1111/0, 2222/1, 3333/2, 4444/3 on consecutive edges. InstrPCPlus1 = InstrPC+1 throughout.
2. Stall for 3 cycles while Instr=2222: outputs hold 2222/1 for all 3 cycles. After release the next outputs are 3333/2 then 4444/3, with no gap or repeat.
3. BranchTaken with BranchTarget=8 while Instr=2222: InstrValid=0 for 2 edges, then 8888/8 followed by 9999/9.
4. BranchTaken and Stall asserted together: the flush occurs (InstrValid=0 next edge) and 8888/8 follows 2 edges later.
5. ResetVector=16'hFFFF: outputs are mem[FFFF]/FFFF, then mem[0]/0. InstrPCPlus1 for FFFF reads 0.
6. RST_n pulsed low mid-stream asynchronously, between edges: InstrValid=0 and ReadAddr=ResetVector immediately. After release the sequence restarts as in scenario 1.
